// File: rtl/mem_ctrl_pkg.sv
// Shared types and limits for the multi-channel memory controller.
package mem_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mc_state_t;

    // Supported parameter ranges
    localparam int NCH_MIN    = 1;
    localparam int NCH_MAX    = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Latency counter only ever holds RD_LAT-1, so log2 of the maximum is enough
    localparam int LAT_W = $clog2(RD_LAT_MAX);

    // Width of a channel index; a single channel still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_mc_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the channel after
// the last winner and wraps around, so every requester is reached within NCH grants.
module rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter  int NCH   = 2,
    localparam int IDX_W = idx_width(NCH)
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] rr_last,
    output logic [NCH-1:0]   win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    logic [IDX_W:0]   sum_w    [NCH];
    logic [IDX_W-1:0] cand_idx [NCH];
    logic [NCH-1:0]   cand_req;

    // Candidate gi is channel (rr_last + gi + 1) mod NCH; the sum never
    // exceeds 2*NCH-1, so one conditional subtraction replaces the modulo
    for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
        assign sum_w[gi]    = {1'b0, rr_last} + (IDX_W+1)'(gi + 1);
        assign cand_idx[gi] = (sum_w[gi] >= (IDX_W+1)'(NCH))
                            ? IDX_W'(sum_w[gi] - (IDX_W+1)'(NCH))
                            : sum_w[gi][IDX_W-1:0];
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    // Scan from the farthest candidate down so the nearest requester wins
    always_comb begin
        win_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    assign win_valid  = |req;
    assign win_onehot = win_valid ? (NCH'(1) << win_idx) : '0;

endmodule

// File: rtl/mem_ctrl_mc.sv
// Multi-channel memory controller: round-robin arbitration of NCH requesters
// onto one single-port synchronous memory, one transaction in flight at a time.
module mem_ctrl_mc
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int NCH       = 2,
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 1
) (
    input  logic                  mc_clk,
    input  logic                  mc_reset,
    input  logic [NCH-1:0]        mc_req,
    input  logic [NCH-1:0]        mc_we,
    input  logic [NCH*ADDR_W-1:0] mc_addr,
    input  logic [NCH*DATA_W-1:0] mc_wdata,
    output logic [NCH-1:0]        mc_gnt,
    output logic [NCH-1:0]        mc_rvalid,
    output logic [DATA_W-1:0]     mc_rdata,
    output logic [NCH-1:0]        mc_err,
    output logic                  mc_busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_data_out,
    input  logic [DATA_W-1:0]     mem_data_in
);

    localparam int IDX_W = idx_width(NCH);

    // Depth limit one bit wider than the address so a full-size memory never flags
    localparam logic [ADDR_W:0] DEPTH_LIM = (MEM_DEPTH >= (2 ** ADDR_W))
                                          ? (ADDR_W+1)'(2 ** ADDR_W)
                                          : (ADDR_W+1)'(MEM_DEPTH);

    if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
        $error("mem_ctrl_mc: NCH outside supported range");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("mem_ctrl_mc: RD_LAT outside supported range");
    end

    mc_state_t         state_reg;
    logic [IDX_W-1:0]  rr_last_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic              we_reg;
    logic [NCH-1:0]    gnt_reg;
    logic [NCH-1:0]    err_reg;
    logic [NCH-1:0]    rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic [NCH-1:0]    win_onehot;
    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_we;
    logic              win_in_range;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req        (mc_req),
        .rr_last    (rr_last_reg),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    assign win_addr     = mc_addr[int'(win_idx) * ADDR_W +: ADDR_W];
    assign win_wdata    = mc_wdata[int'(win_idx) * DATA_W +: DATA_W];
    assign win_we       = mc_we[win_idx];
    assign win_in_range = ({1'b0, win_addr} < DEPTH_LIM);

    // Sequencer: all outputs are registered and default to idle each cycle,
    // so grant, error, strobe and rvalid are naturally one-cycle pulses
    always_ff @(posedge mc_clk) begin
        if (!mc_reset) begin
            state_reg     <= ST_IDLE;
            rr_last_reg   <= IDX_W'(NCH - 1);
            lat_cnt_reg   <= '0;
            we_reg        <= 1'b0;
            gnt_reg       <= '0;
            err_reg       <= '0;
            rvalid_reg    <= '0;
            rdata_reg     <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            gnt_reg       <= '0;
            err_reg       <= '0;
            rvalid_reg    <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        rr_last_reg <= win_idx;
                        we_reg      <= win_we;
                        gnt_reg     <= win_onehot;
                        if (win_in_range) begin
                            mem_en_reg    <= 1'b1;
                            mem_we_reg    <= win_we;
                            mem_addr_reg  <= win_addr;
                            mem_wdata_reg <= win_wdata;
                        end else begin
                            err_reg <= win_onehot;
                        end
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Writes and rejected accesses complete here; reads wait for data
                    if (|err_reg || we_reg) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        lat_cnt_reg <= LAT_W'(RD_LAT - 1);
                        state_reg   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_reg == '0) begin
                        rdata_reg  <= mem_data_in;
                        rvalid_reg <= NCH'(1) << rr_last_reg;
                        state_reg  <= ST_RESP;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mc_gnt       = gnt_reg;
    assign mc_err       = err_reg;
    assign mc_rvalid    = rvalid_reg;
    assign mc_rdata     = rdata_reg;
    assign mc_busy      = (state_reg != ST_IDLE);
    assign mem_en       = mem_en_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_data_out = mem_wdata_reg;

endmodule
